fetch_align: RTL and testbench
==============================

# fetch_align

Instruction aligner and halfword queue between the L1 instruction read port and `id`. It accepts 64-bit fetch lines, splits them into RV32 (32-bit) and RVC (16-bit) instructions, and stitches 32-bit instructions that straddle line boundaries. It presents up to four aligned instructions per cycle to `id` as a registered 4-slot fetch buffer. It flushes on `jump_flag_i`/`hold_flag_i` from `ex_j`.

## Interface
- `QDEPTH`, 8: halfword queue depth; a power of two, ≥ 8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `jump_flag_i`  in  1  redirect from `ex_j`; flushes the block.
- `hold_flag_i`  in  1  hold from `ex_j`; flushes the block.
- `line_en_i`  in  1  fetch line valid.
- `line_i`  in  64  fetch line; halfword k = `line_i[16k+15:16k]`.
- `line_addr_i`  in  32  fetch address; bit 0 always 0.
- `line_ready_o`  out  1  queue can take a full line.
- `fb_o`  out  128  slot i = `fb_o[32i+31:32i]`.
- `fb_addr_o`  out  128  slot i = `fb_addr_o[32i+31:32i]`, PC of slot i.
- `fb_en_o`  out  4  slot valid mask; always contiguous from bit 0.
- `full_flag_i`  in  1  `id` cannot take the presented slots this cycle.

## Operation
- Line geometry:
  - Base = `{line_addr_i[31:3],3'b0}`; offset = `line_addr_i[2:1]`.
  - Halfwords with index < offset are dropped.
  - Halfwords offset..3 are pushed in order, at addresses base+2k.
- Queue:
  - Circular buffer of `QDEPTH` halfwords, each with a 32-bit address.
  - 4-bit `count` (0..QDEPTH); wrapping head and tail pointers.
- Accept:
  - A line is accepted when `line_en_i` and `line_ready_o` are both high.
  - `line_ready_o` = (`count` ≤ `QDEPTH`−4), computed from registered `count`. It is never reduced by a same-cycle pop.
- Continuity:
  - `exp_addr` register holds the address of the next expected halfword. `exp_valid` marks it as set.
  - When `exp_valid`=0, any accepted line is pushed. `exp_addr` becomes base+8 and `exp_valid` becomes 1.
  - When `exp_valid`=1, an accepted line whose first kept halfword address ≠ `exp_addr` is discarded entirely; queue and `exp_addr` are unchanged.
- Extraction (combinational, from the head):
  - Walk up to 4 instructions.
  - Halfword with `[1:0]`≠2'b11: 16-bit instruction, zero-extended into the 32-bit slot, consumes 1 halfword.
  - Otherwise: 32-bit instruction, `{hw[n+1],hw[n]}`, consumes 2 halfwords. It is valid only if hw[n+1] is present.
  - The walk stops at the first incomplete instruction. A lone upper-half-pending 32-bit instruction waits in the queue.
- Output register update:
  - Load the fb registers when `fb_en_o`==0 or `full_flag_i`==0. On a load, pop the consumed halfwords.
  - Otherwise hold `fb_o`, `fb_addr_o` and `fb_en_o` unchanged, and pop nothing.
- Concurrent push and pop in the same cycle: `count` ← `count` + pushed − popped.
- Flush (`jump_flag_i` or `hold_flag_i` high at an edge):
  - `count`, pointers and `fb_en_o` go to 0; `exp_valid` goes to 0.
  - Any line presented in that cycle is discarded.
  - Flush has priority over push, pop and output load.

## Timing
- Reset values: `fb_o`=0, `fb_addr_o`=0, `fb_en_o`=0, `count`=0, `exp_valid`=0, `line_ready_o`=1.
- Reset asserted mid-operation clears all state immediately; no partial instruction survives.
- Latency, line to `fb_en_o`:
  - Line accepted at edge N is written to the queue at edge N.
  - It is visible in `fb_o` after edge N+1, provided the fb registers load at N+1.
- Throughput: up to 4 instructions per cycle out; 4 halfwords per cycle in.
- Flush at edge N: `fb_en_o`=0 from N. The first post-flush line accepted at edge N+1 appears in `fb_o` after N+2.
- `full_flag_i` high with `fb_en_o`≠0: outputs hold every cycle until `full_flag_i` drops. The queue keeps filling until `line_ready_o` falls.
- Empty queue with load enabled: `fb_en_o` becomes 0.
- Full queue (`count`=8): `line_ready_o`=0. It rises only after a pop lowers `count` to ≤4.

## Test plan
- **Aligned RV32:** reset, then line addr 0x0, data four 16-bit halfwords forming 0x00000013 and 0x00100093 -> after 2 edges `fb_en_o`=4'b0011, slot0=0x00000013@0x0, slot1=0x00100093@0x4.
- **Mixed RVC/RV32:** line addr 0x0, halfwords 0x4501, 0x0513, 0x0000, 0x4585 -> after 2 edges `fb_en_o`=4'b0111:
  - slot0=0x00004501@0x0;
  - slot1=0x00000513@0x2;
  - slot2=0x00004585@0x6.
- **Straddle:** line 0x0 ending with a lower halfword 0x0093 at 0x6, then line 0x8 starting 0x0010 -> 0x00100093@0x6 is emitted only after the second line, in one slot.
- **Unaligned entry:** line addr 0x6 -> halfwords 0..2 dropped. `exp_addr`=0x8. A following line at 0x10 is discarded and `fb_en_o` stays 0.
- **Backpressure:** hold `full_flag_i`=1 while streaming -> `fb_o`/`fb_en_o` stable; `line_ready_o` falls when `count`>4. Releasing `full_flag_i` pops and refills with no lost or duplicated instructions.
- **Flush collision:** `jump_flag_i`=1 on the same edge as `line_en_i`=1 and an output load -> queue empty, `fb_en_o`=0, line dropped. The next line at any address is accepted.

Source files
------------

// File: rtl/fetch_align.sv
// Instruction aligner: queues fetch-line halfwords, stitches RV32 instructions across
// line boundaries and presents up to four aligned instructions per cycle to decode.
module fetch_align #(
    parameter int QDEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         jump_flag_i,
    input  logic         hold_flag_i,
    input  logic         line_en_i,
    input  logic [63:0]  line_i,
    input  logic [31:0]  line_addr_i,
    output logic         line_ready_o,
    output logic [127:0] fb_o,
    output logic [127:0] fb_addr_o,
    output logic [3:0]   fb_en_o,
    input  logic         full_flag_i
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [15:0]   q_data [QDEPTH];
    logic [31:0]   q_addr [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   exp_addr;
    logic          exp_valid;

    logic          flush;
    logic [31:0]   line_base;
    logic [31:0]   first_addr;
    logic [1:0]    offset;
    logic          addr_match;
    logic          push;
    logic [CW-1:0] push_cnt;
    logic [3:0]    wr_en;
    logic [PW-1:0] wr_idx [4];
    logic          unused_addr_bit;

    logic [15:0]   pk_data [8];
    logic [31:0]   pk_addr [8];
    logic [CW-1:0] pop_cnt;
    logic [127:0]  nxt_fb;
    logic [127:0]  nxt_addr;
    logic [3:0]    nxt_en;
    logic          walk_stop;
    logic [2:0]    ix0;
    logic [2:0]    ix1;
    logic          load;

    assign flush           = jump_flag_i | hold_flag_i;
    assign line_base       = {line_addr_i[31:3], 3'b000};
    assign offset          = line_addr_i[2:1];
    assign first_addr      = {line_addr_i[31:1], 1'b0};
    assign unused_addr_bit = line_addr_i[0];

    // Ready looks only at registered occupancy so it never depends on this cycle's pop.
    assign line_ready_o = (count <= CW'(QDEPTH - 4));
    assign addr_match   = !exp_valid || (first_addr == exp_addr);
    assign push         = line_en_i && line_ready_o && !flush && addr_match;
    assign push_cnt     = CW'(3'd4 - {1'b0, offset});

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            wr_en[k]  = push && (k >= int'(offset));
            wr_idx[k] = tail + PW'(k) - PW'(offset);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) begin
                q_data[wr_idx[k]] <= line_i[16*k +: 16];
                q_addr[wr_idx[k]] <= line_base + 32'(2 * k);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            pk_data[j] = q_data[head + PW'(j)];
            pk_addr[j] = q_addr[head + PW'(j)];
        end
    end

    // Walk from the head; a 32-bit instruction whose upper half has not arrived ends the walk.
    always_comb begin
        pop_cnt   = '0;
        nxt_fb    = '0;
        nxt_addr  = '0;
        nxt_en    = '0;
        walk_stop = 1'b0;
        ix0       = '0;
        ix1       = '0;
        for (int s = 0; s < 4; s++) begin
            ix0 = pop_cnt[2:0];
            ix1 = ix0 + 3'd1;
            if (!walk_stop) begin
                if (pop_cnt >= count) begin
                    walk_stop = 1'b1;
                end else if (pk_data[ix0][1:0] != 2'b11) begin
                    nxt_fb[32*s +: 32]   = {16'h0000, pk_data[ix0]};
                    nxt_addr[32*s +: 32] = pk_addr[ix0];
                    nxt_en[s]            = 1'b1;
                    pop_cnt              = pop_cnt + CW'(1);
                end else if ((pop_cnt + CW'(1)) < count) begin
                    nxt_fb[32*s +: 32]   = {pk_data[ix1], pk_data[ix0]};
                    nxt_addr[32*s +: 32] = pk_addr[ix0];
                    nxt_en[s]            = 1'b1;
                    pop_cnt              = pop_cnt + CW'(2);
                end else begin
                    walk_stop = 1'b1;
                end
            end
        end
    end

    assign load = (fb_en_o == 4'b0000) || !full_flag_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            exp_addr  <= '0;
            exp_valid <= 1'b0;
            fb_o      <= '0;
            fb_addr_o <= '0;
            fb_en_o   <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            exp_valid <= 1'b0;
            fb_en_o   <= '0;
        end else begin
            if (push) begin
                tail      <= tail + push_cnt[PW-1:0];
                exp_addr  <= line_base + 32'd8;
                exp_valid <= 1'b1;
            end
            if (load) begin
                fb_o      <= nxt_fb;
                fb_addr_o <= nxt_addr;
                fb_en_o   <= nxt_en;
                head      <= head + pop_cnt[PW-1:0];
            end
            count <= count + (push ? push_cnt : '0) - (load ? pop_cnt : '0);
        end
    end

endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: directed scenarios plus randomized traffic against a
// halfword-queue reference model.
module tb_fetch_align;
    logic         clk;
    logic         rst;
    logic         jump_flag_i;
    logic         hold_flag_i;
    logic         line_en_i;
    logic [63:0]  line_i;
    logic [31:0]  line_addr_i;
    logic         line_ready_o;
    logic [127:0] fb_o;
    logic [127:0] fb_addr_o;
    logic [3:0]   fb_en_o;
    logic         full_flag_i;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [31:0] a;
    } hw_t;

    hw_t         mq[$];
    logic [31:0] m_fb [4];
    logic [31:0] m_fa [4];
    int          m_n;
    logic [31:0] m_exp;
    bit          m_expv;

    fetch_align #(.QDEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag_i),
        .hold_flag_i  (hold_flag_i),
        .line_en_i    (line_en_i),
        .line_i       (line_i),
        .line_addr_i  (line_addr_i),
        .line_ready_o (line_ready_o),
        .fb_o         (fb_o),
        .fb_addr_o    (fb_addr_o),
        .fb_en_o      (fb_en_o),
        .full_flag_i  (full_flag_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    task automatic model_reset();
        mq.delete();
        m_n    = 0;
        m_expv = 0;
        m_exp  = '0;
        for (int i = 0; i < 4; i++) begin
            m_fb[i] = '0;
            m_fa[i] = '0;
        end
    endtask

    // Advance one clock edge, updating the model from the rules, then settle 1 ns.
    task automatic step();
        int          n;
        int          p;
        int          off;
        logic [31:0] ins [4];
        logic [31:0] ad [4];
        bit          ld;
        bit          rdy;
        bit          fl;
        bit          en;
        logic [31:0] base;
        logic [31:0] first;
        logic [63:0] data;
        hw_t         h;
        fl    = jump_flag_i || hold_flag_i;
        rdy   = (mq.size() <= 4);
        en    = line_en_i;
        data  = line_i;
        base  = {line_addr_i[31:3], 3'b000};
        off   = int'(line_addr_i[2:1]);
        first = base + 32'(2 * off);
        n = 0;
        p = 0;
        while (n < 4 && p < mq.size()) begin
            if (mq[p].d[1:0] != 2'b11) begin
                ins[n] = {16'h0000, mq[p].d};
                ad[n]  = mq[p].a;
                n++;
                p++;
            end else if (p + 1 < mq.size()) begin
                ins[n] = {mq[p+1].d, mq[p].d};
                ad[n]  = mq[p].a;
                n++;
                p += 2;
            end else begin
                break;
            end
        end
        ld = (m_n == 0) || !full_flag_i;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_n    = 0;
            m_expv = 0;
        end else begin
            if (ld) begin
                for (int i = 0; i < p; i++) void'(mq.pop_front());
                m_n = n;
                for (int i = 0; i < n; i++) begin
                    m_fb[i] = ins[i];
                    m_fa[i] = ad[i];
                end
            end
            if (en && rdy && (!m_expv || first == m_exp)) begin
                for (int k = off; k < 4; k++) begin
                    h.d = data[16*k +: 16];
                    h.a = base + 32'(2 * k);
                    mq.push_back(h);
                end
                m_exp  = base + 32'd8;
                m_expv = 1;
            end
        end
        #1;
    endtask

    task automatic drive_line(input logic [31:0] addr, input logic [63:0] data);
        line_en_i   = 1'b1;
        line_addr_i = addr;
        line_i      = data;
    endtask

    task automatic idle();
        line_en_i = 1'b0;
    endtask

    task automatic do_flush();
        idle();
        jump_flag_i = 1'b1;
        step();
        jump_flag_i = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        jump_flag_i = 1'b0;
        hold_flag_i = 1'b0;
        line_en_i   = 1'b0;
        line_i      = '0;
        line_addr_i = '0;
        full_flag_i = 1'b0;
        model_reset();
        #12;
        checks++;
        if (fb_en_o !== 4'b0000) begin
            errors++;
            $display("FAIL reset_fb_en got %b want 0000", fb_en_o);
        end
        checks++;
        if (line_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_line_ready got %b want 1", line_ready_o);
        end
        checks++;
        if (fb_o !== 128'h0 || fb_addr_o !== 128'h0) begin
            errors++;
            $display("FAIL reset_fb_data got %h / %h want zero", fb_o, fb_addr_o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_aligned_rv32();
        do_flush();
        drive_line(32'h0, {16'h0010, 16'h0093, 16'h0000, 16'h0013});
        step();
        idle();
        checks++;
        if (fb_en_o !== 4'b0000) begin
            errors++;
            $display("FAIL aligned_latency got %b want 0000", fb_en_o);
        end
        step();
        checks++;
        if (fb_en_o !== 4'b0011) begin
            errors++;
            $display("FAIL aligned_en got %b want 0011", fb_en_o);
        end
        checks++;
        if (fb_o[31:0] !== 32'h00000013 || fb_addr_o[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL aligned_slot0 got %h@%h want 00000013@0", fb_o[31:0], fb_addr_o[31:0]);
        end
        checks++;
        if (fb_o[63:32] !== 32'h00100093 || fb_addr_o[63:32] !== 32'h4) begin
            errors++;
            $display("FAIL aligned_slot1 got %h@%h want 00100093@4", fb_o[63:32], fb_addr_o[63:32]);
        end
    endtask

    task automatic test_mixed();
        do_flush();
        drive_line(32'h0, {16'h4585, 16'h0000, 16'h0513, 16'h4501});
        step();
        idle();
        step();
        checks++;
        if (fb_en_o !== 4'b0111) begin
            errors++;
            $display("FAIL mixed_en got %b want 0111", fb_en_o);
        end
        checks++;
        if (fb_o[31:0] !== 32'h00004501 || fb_addr_o[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL mixed_slot0 got %h@%h want 00004501@0", fb_o[31:0], fb_addr_o[31:0]);
        end
        checks++;
        if (fb_o[63:32] !== 32'h00000513 || fb_addr_o[63:32] !== 32'h2) begin
            errors++;
            $display("FAIL mixed_slot1 got %h@%h want 00000513@2", fb_o[63:32], fb_addr_o[63:32]);
        end
        checks++;
        if (fb_o[95:64] !== 32'h00004585 || fb_addr_o[95:64] !== 32'h6) begin
            errors++;
            $display("FAIL mixed_slot2 got %h@%h want 00004585@6", fb_o[95:64], fb_addr_o[95:64]);
        end
    endtask

    task automatic test_straddle();
        do_flush();
        drive_line(32'h0, {16'h0093, 16'h0001, 16'h0001, 16'h0001});
        step();
        drive_line(32'h8, {16'h0001, 16'h0001, 16'h0001, 16'h0010});
        step();
        idle();
        checks++;
        if (fb_en_o !== 4'b0111 || fb_addr_o[95:64] !== 32'h4) begin
            errors++;
            $display("FAIL straddle_wait got %b last@%h want 0111 last@4", fb_en_o, fb_addr_o[95:64]);
        end
        step();
        checks++;
        if (fb_en_o !== 4'b1111) begin
            errors++;
            $display("FAIL straddle_en got %b want 1111", fb_en_o);
        end
        checks++;
        if (fb_o[31:0] !== 32'h00100093 || fb_addr_o[31:0] !== 32'h6) begin
            errors++;
            $display("FAIL straddle_slot0 got %h@%h want 00100093@6", fb_o[31:0], fb_addr_o[31:0]);
        end
        checks++;
        if (fb_addr_o[63:32] !== 32'hA) begin
            errors++;
            $display("FAIL straddle_slot1_addr got %h want 0000000a", fb_addr_o[63:32]);
        end
    endtask

    task automatic test_unaligned();
        do_flush();
        drive_line(32'h6, {16'h0093, 16'hAAAA, 16'hBBBB, 16'hCCCC});
        step();
        drive_line(32'h10, {4{16'h0001}});
        step();
        idle();
        step();
        checks++;
        if (fb_en_o !== 4'b0000) begin
            errors++;
            $display("FAIL unaligned_discard got %b want 0000", fb_en_o);
        end
        step();
        checks++;
        if (fb_en_o !== 4'b0000 || line_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL unaligned_still_empty got en %b rdy %b want 0000 1", fb_en_o, line_ready_o);
        end
        drive_line(32'h8, {16'h0001, 16'h0001, 16'h0001, 16'h0010});
        step();
        idle();
        step();
        checks++;
        if (fb_en_o !== 4'b1111 || fb_o[31:0] !== 32'h00100093 || fb_addr_o[31:0] !== 32'h6) begin
            errors++;
            $display("FAIL unaligned_resume got %b %h@%h want 1111 00100093@6", fb_en_o, fb_o[31:0], fb_addr_o[31:0]);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]  em;
        logic [31:0] r;
        logic [63:0] d;
        do_flush();
        full_flag_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            for (int k = 0; k < 4; k++) begin
                r = $urandom();
                d[16*k +: 16] = {r[15:2], 2'b01};
            end
            drive_line(m_expv ? m_exp : 32'h200, d);
            step();
            em = 4'((1 << m_n) - 1);
            checks++;
            if (fb_en_o !== em || line_ready_o !== (mq.size() <= 4)) begin
                errors++;
                $display("FAIL bp_hold_state cyc %0d got en %b rdy %b want en %b rdy %b", c, fb_en_o, line_ready_o, em, (mq.size() <= 4));
            end
            for (int i = 0; i < m_n; i++) begin
                checks++;
                if (fb_o[32*i +: 32] !== m_fb[i] || fb_addr_o[32*i +: 32] !== m_fa[i]) begin
                    errors++;
                    $display("FAIL bp_hold_slot%0d cyc %0d got %h@%h want %h@%h", i, c, fb_o[32*i +: 32], fb_addr_o[32*i +: 32], m_fb[i], m_fa[i]);
                end
            end
        end
        checks++;
        if (line_ready_o !== 1'b0 || fb_en_o !== 4'b1111 || fb_addr_o[31:0] !== 32'h200 || fb_addr_o[127:96] !== 32'h206) begin
            errors++;
            $display("FAIL bp_full got rdy %b en %b a0 %h a3 %h want 0 1111 200 206", line_ready_o, fb_en_o, fb_addr_o[31:0], fb_addr_o[127:96]);
        end
        full_flag_i = 1'b0;
        idle();
        for (int c = 0; c < 8; c++) begin
            step();
            em = 4'((1 << m_n) - 1);
            checks++;
            if (fb_en_o !== em) begin
                errors++;
                $display("FAIL bp_drain_en cyc %0d got %b want %b", c, fb_en_o, em);
            end
            for (int i = 0; i < m_n; i++) begin
                checks++;
                if (fb_o[32*i +: 32] !== m_fb[i] || fb_addr_o[32*i +: 32] !== m_fa[i]) begin
                    errors++;
                    $display("FAIL bp_drain_slot%0d cyc %0d got %h@%h want %h@%h", i, c, fb_o[32*i +: 32], fb_addr_o[32*i +: 32], m_fb[i], m_fa[i]);
                end
            end
        end
        checks++;
        if (fb_en_o !== 4'b0000 || line_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_drained got en %b rdy %b want 0000 1", fb_en_o, line_ready_o);
        end
    endtask

    task automatic test_flush_collision();
        do_flush();
        drive_line(32'h40, {4{16'h0001}});
        step();
        drive_line(32'h48, {4{16'h0001}});
        jump_flag_i = 1'b1;
        step();
        jump_flag_i = 1'b0;
        idle();
        checks++;
        if (fb_en_o !== 4'b0000 || line_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_collision got en %b rdy %b want 0000 1", fb_en_o, line_ready_o);
        end
        step();
        checks++;
        if (fb_en_o !== 4'b0000) begin
            errors++;
            $display("FAIL flush_line_dropped got %b want 0000", fb_en_o);
        end
        drive_line(32'h300, {4{16'h0001}});
        step();
        idle();
        step();
        checks++;
        if (fb_en_o !== 4'b1111 || fb_addr_o[31:0] !== 32'h300) begin
            errors++;
            $display("FAIL flush_next_line got %b @%h want 1111 @00000300", fb_en_o, fb_addr_o[31:0]);
        end
    endtask

    task automatic test_midop_reset();
        do_flush();
        drive_line(32'h80, {4{16'h0001}});
        step();
        drive_line(32'h88, {4{16'h0001}});
        step();
        idle();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (fb_en_o !== 4'b0000 || line_ready_o !== 1'b1 || fb_o !== 128'h0) begin
            errors++;
            $display("FAIL midop_reset got en %b rdy %b fb %h want 0000 1 0", fb_en_o, line_ready_o, fb_o);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive_line(32'h1002, {16'h0001, 16'h0001, 16'h0001, 16'h0093});
        step();
        idle();
        step();
        checks++;
        if (fb_en_o !== 4'b0111 || fb_addr_o[31:0] !== 32'h1002 || fb_addr_o[95:64] !== 32'h1006) begin
            errors++;
            $display("FAIL midop_after_reset got %b %h..%h want 0111 1002..1006", fb_en_o, fb_addr_o[31:0], fb_addr_o[95:64]);
        end
    endtask

    task automatic test_random();
        int          r;
        logic [31:0] a;
        logic [3:0]  em;
        do_flush();
        for (int c = 0; c < 1500; c++) begin
            r = int'($urandom_range(0, 99));
            jump_flag_i = (r < 2);
            hold_flag_i = (r >= 2 && r < 4);
            full_flag_i = ($urandom_range(0, 99) < 35);
            line_en_i   = ($urandom_range(0, 99) < 70);
            line_i      = {$urandom(), $urandom()};
            a = $urandom();
            a[0] = 1'b0;
            if (m_expv && $urandom_range(0, 9) != 0) a = m_exp;
            line_addr_i = a;
            step();
            em = 4'((1 << m_n) - 1);
            checks++;
            if (line_ready_o !== (mq.size() <= 4)) begin
                errors++;
                $display("FAIL rand_ready cyc %0d got %b want %b", c, line_ready_o, (mq.size() <= 4));
            end
            checks++;
            if (fb_en_o !== em) begin
                errors++;
                $display("FAIL rand_en cyc %0d got %b want %b", c, fb_en_o, em);
            end
            for (int i = 0; i < m_n; i++) begin
                checks++;
                if (fb_o[32*i +: 32] !== m_fb[i] || fb_addr_o[32*i +: 32] !== m_fa[i]) begin
                    errors++;
                    $display("FAIL rand_slot%0d cyc %0d got %h@%h want %h@%h", i, c, fb_o[32*i +: 32], fb_addr_o[32*i +: 32], m_fb[i], m_fa[i]);
                end
            end
        end
        jump_flag_i = 1'b0;
        hold_flag_i = 1'b0;
        full_flag_i = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_aligned_rv32();
        test_mixed();
        test_straddle();
        test_unaligned();
        test_backpressure();
        test_flush_collision();
        test_midop_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
